// File: rtl/banked_byte_register_pkg.sv
// banked_byte_register_pkg: shared lane geometry defaults and byte-order constants
package banked_byte_register_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int WORD_DEF = 4;
  localparam int FULLW_DEF = WIDTH_DEF * WORD_DEF;
  localparam logic BYTE_ORDER_BIG = 1'b1;
  localparam logic BYTE_ORDER_LITTLE = 1'b0;
endpackage

// File: rtl/banked_byte_register_swap.sv
// byte_order_swap: maps external lanes to internal MSB-first byte order; the map is its own inverse
module byte_order_swap
  import banked_byte_register_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int WORD = WORD_DEF
) (
  input  logic                    big_endian,
  input  logic [WIDTH*WORD-1:0]   a,
  output logic [WIDTH*WORD-1:0]   y
);
  logic [WIDTH*WORD-1:0] rev;
  for (genvar k = 0; k < WORD; k++) begin : g_lane
    assign rev[k*WIDTH +: WIDTH] = a[(WORD-1-k)*WIDTH +: WIDTH];
  end
  always_comb y = (big_endian == BYTE_ORDER_BIG) ? a : rev;
endmodule

// File: rtl/banked_byte_register.sv
// banked_byte_register: DEPTH-entry byte-strobed register bank with endian modes and shadow save/restore/swap
module banked_byte_register
  import banked_byte_register_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int WORD = WORD_DEF,
  parameter int DEPTH = 4,
  parameter int ADDRW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDRW-1:0]      waddr,
  input  logic [WORD-1:0]       wbe,
  input  logic [WIDTH*WORD-1:0] d,
  input  logic                  big_endian,
  input  logic                  re,
  input  logic [ADDRW-1:0]      raddr,
  input  logic                  save,
  input  logic                  restore,
  output logic [WIDTH*WORD-1:0] q,
  output logic                  q_valid,
  output logic                  rd_err
);
  localparam logic [ADDRW:0] LIM = (ADDRW+1)'(DEPTH);
  logic [WIDTH*WORD-1:0] live_q [DEPTH];
  logic [WIDTH*WORD-1:0] live_d [DEPTH];
  logic [WIDTH*WORD-1:0] shad_q [DEPTH];
  logic [WIDTH*WORD-1:0] shad_d [DEPTH];
  logic [DEPTH-1:0] wr_q, wr_d, swr_q, swr_d;
  logic [WIDTH*WORD-1:0] wdata, mask, rraw, rdata, q_q, q_d;
  logic q_valid_q, q_valid_d, rd_err_q, rd_err_d, wok, rok;
  byte_order_swap #(.WIDTH(WIDTH), .WORD(WORD)) u_wswap (.big_endian(big_endian), .a(d), .y(wdata));
  byte_order_swap #(.WIDTH(WIDTH), .WORD(WORD)) u_rswap (.big_endian(big_endian), .a(rraw), .y(rdata));
  // Bank op first, then the write merges on top, then the read sees the merged result.
  always_comb begin
    for (int p = 0; p < WORD; p++)
      mask[p*WIDTH +: WIDTH] = {WIDTH{(big_endian == BYTE_ORDER_LITTLE) ? wbe[WORD-1-p] : wbe[p]}};
    wok = we && (|wbe) && ({1'b0, waddr} < LIM);
    rok = {1'b0, raddr} < LIM;
    for (int a = 0; a < DEPTH; a++) begin
      live_d[a] = restore ? shad_q[a] : live_q[a];
      shad_d[a] = save ? live_q[a] : shad_q[a];
    end
    wr_d = restore ? swr_q : wr_q;
    swr_d = save ? wr_q : swr_q;
    if (wok) begin
      live_d[waddr] = (live_d[waddr] & ~mask) | (wdata & mask);
      wr_d[waddr] = 1'b1;
    end
    rraw = rok ? live_d[raddr] : '0;
    rd_err_d = re && !(rok && wr_d[raddr]);
  end
  always_comb begin
    q_d = re ? rdata : q_q;
    q_valid_d = re;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live_q <= '{default: '0};
      shad_q <= '{default: '0};
      wr_q <= '0;
      swr_q <= '0;
      q_q <= '0;
      q_valid_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      live_q <= live_d;
      shad_q <= shad_d;
      wr_q <= wr_d;
      swr_q <= swr_d;
      q_q <= q_d;
      q_valid_q <= q_valid_d;
      rd_err_q <= rd_err_d;
    end
  end
  assign q = q_q;
  assign q_valid = q_valid_q;
  assign rd_err = rd_err_q;
endmodule

// File: tb/tb_banked_byte_register.sv
// tb_banked_byte_register: directed and randomized checks of a DEPTH=4 and a DEPTH=3 bank against a byte-array model
module tb_banked_byte_register;
  logic clk = 1'b0, rst_n = 1'b0, we = 1'b0, big = 1'b1, re = 1'b0, save = 1'b0, restore = 1'b0;
  logic [1:0] waddr = '0, raddr = '0;
  logic [3:0] wbe = '0;
  logic [31:0] d = '0;
  logic [31:0] q4, q3;
  logic qv4, qv3, e4, e3;
  int vec = 0, errs = 0;
  logic [7:0] lv [2][4][4];
  logic [7:0] sh [2][4][4];
  logic lw [2][4];
  logic sw [2][4];
  logic [31:0] mq [2];
  logic mv [2];
  logic me [2];

  always #5 clk = ~clk;

  banked_byte_register #(.WIDTH(8), .WORD(4), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wbe(wbe), .d(d), .big_endian(big),
    .re(re), .raddr(raddr), .save(save), .restore(restore), .q(q4), .q_valid(qv4), .rd_err(e4));
  banked_byte_register #(.WIDTH(8), .WORD(4), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wbe(wbe), .d(d), .big_endian(big),
    .re(re), .raddr(raddr), .save(save), .restore(restore), .q(q3), .q_valid(qv3), .rd_err(e3));

  // Model keeps bytes with index 0 as the most-significant, as the behaviour is described.
  task automatic model(input int n);
    int dep;
    logic [7:0] old;
    logic ow;
    dep = (n == 0) ? 4 : 3;
    if (!rst_n) begin
      for (int a = 0; a < 4; a++) begin
        lw[n][a] = 1'b0;
        sw[n][a] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          lv[n][a][i] = 8'h00;
          sh[n][a][i] = 8'h00;
        end
      end
      mq[n] = 32'h0;
      mv[n] = 1'b0;
      me[n] = 1'b0;
      return;
    end
    for (int a = 0; a < 4; a++) begin
      ow = lw[n][a];
      if (restore) lw[n][a] = sw[n][a];
      if (save) sw[n][a] = ow;
      for (int i = 0; i < 4; i++) begin
        old = lv[n][a][i];
        if (restore) lv[n][a][i] = sh[n][a][i];
        if (save) sh[n][a][i] = old;
      end
    end
    if (we && int'(waddr) < dep)
      for (int k = 0; k < 4; k++)
        if (wbe[k]) begin
          lv[n][waddr][big ? 3 - k : k] = d[k*8 +: 8];
          lw[n][waddr] = 1'b1;
        end
    mv[n] = re;
    me[n] = 1'b0;
    if (re) begin
      if (int'(raddr) >= dep) begin
        mq[n] = 32'h0;
        me[n] = 1'b1;
      end else begin
        for (int k = 0; k < 4; k++) mq[n][k*8 +: 8] = lv[n][raddr][big ? 3 - k : k];
        me[n] = !lw[n][raddr];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model(0);
    model(1);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] x, input logic b);
    we = 1'b1; waddr = a; wbe = be; d = x; big = b;
    tick();
    we = 1'b0; wbe = '0;
  endtask

  task automatic rd(input logic [1:0] a, input logic b);
    re = 1'b1; raddr = a; big = b;
    tick();
    re = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    vec++;
    if ({q4, qv4, e4} !== 34'h0) begin errs++; $display("FAIL reset_outputs: got %h/%b/%b want 0/0/0", q4, qv4, e4); end
    rst_n = 1'b1;
    rd(2'd0, 1'b1);
    vec++;
    if ({q4, qv4, e4} !== {32'h0, 1'b1, 1'b1}) begin errs++; $display("FAIL reset_read: got %h/%b/%b want 00000000/1/1", q4, qv4, e4); end
    tick();
    vec++;
    if ({q4, qv4, e4} !== {32'h0, 1'b0, 1'b0}) begin errs++; $display("FAIL idle_hold: got %h/%b/%b want 00000000/0/0", q4, qv4, e4); end
  endtask

  task automatic test_endian();
    wr(2'd1, 4'hF, 32'h11223344, 1'b1);
    rd(2'd1, 1'b1);
    vec++;
    if ({q4, qv4, e4} !== {32'h11223344, 1'b1, 1'b0}) begin errs++; $display("FAIL be_roundtrip: got %h/%b/%b want 11223344/1/0", q4, qv4, e4); end
    rd(2'd1, 1'b0);
    vec++;
    if ({q4, qv4, e4} !== {32'h44332211, 1'b1, 1'b0}) begin errs++; $display("FAIL le_cross: got %h/%b/%b want 44332211/1/0", q4, qv4, e4); end
    wr(2'd1, 4'hF, 32'hA1B2C3D4, 1'b0);
    rd(2'd1, 1'b0);
    vec++;
    if (q4 !== 32'hA1B2C3D4) begin errs++; $display("FAIL le_roundtrip: got %h want a1b2c3d4", q4); end
  endtask

  task automatic test_strobes();
    wr(2'd2, 4'hF, 32'hAABBCCDD, 1'b1);
    wr(2'd2, 4'b0011, 32'h00001234, 1'b1);
    rd(2'd2, 1'b1);
    vec++;
    if (q4 !== 32'hAABB1234) begin errs++; $display("FAIL strobe_be: got %h want aabb1234", q4); end
    wr(2'd2, 4'b0001, 32'h000000EE, 1'b0);
    rd(2'd2, 1'b1);
    vec++;
    if (q4 !== 32'hEEBB1234) begin errs++; $display("FAIL strobe_le: got %h want eebb1234", q4); end
  endtask

  task automatic test_forward();
    we = 1'b1; waddr = 2'd3; wbe = 4'hF; d = 32'hDEADBEEF; big = 1'b1; re = 1'b1; raddr = 2'd3;
    tick();
    we = 1'b0; wbe = '0; re = 1'b0;
    vec++;
    if ({q4, qv4, e4} !== {32'hDEADBEEF, 1'b1, 1'b0}) begin errs++; $display("FAIL forward: got %h/%b/%b want deadbeef/1/0", q4, qv4, e4); end
    vec++;
    if ({q3, qv3, e3} !== {32'h0, 1'b1, 1'b1}) begin errs++; $display("FAIL oor_fwd_d3: got %h/%b/%b want 00000000/1/1", q3, qv3, e3); end
    rd(2'd3, 1'b1);
    vec++;
    if ({q3, qv3, e3} !== {32'h0, 1'b1, 1'b1}) begin errs++; $display("FAIL oor_read_d3: got %h/%b/%b want 00000000/1/1", q3, qv3, e3); end
  endtask

  task automatic test_banking();
    wr(2'd0, 4'hF, 32'h1, 1'b1);
    save = 1'b1; tick(); save = 1'b0;
    wr(2'd0, 4'hF, 32'h2, 1'b1);
    save = 1'b1; restore = 1'b1; tick(); save = 1'b0; restore = 1'b0;
    rd(2'd0, 1'b1);
    vec++;
    if (q4 !== 32'h1) begin errs++; $display("FAIL swap: got %h want 00000001", q4); end
    restore = 1'b1;
    wr(2'd0, 4'hF, 32'h3, 1'b1);
    restore = 1'b0;
    rd(2'd0, 1'b1);
    vec++;
    if (q4 !== 32'h3) begin errs++; $display("FAIL restore_write: got %h want 00000003", q4); end
    restore = 1'b1; tick(); restore = 1'b0;
    rd(2'd0, 1'b1);
    vec++;
    if (q4 !== 32'h2) begin errs++; $display("FAIL restore_again: got %h want 00000002", q4); end
  endtask

  task automatic test_reset_during_save();
    save = 1'b1; rst_n = 1'b0; tick(); save = 1'b0; rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), 1'b1);
      vec++;
      if ({q4, qv4, e4} !== {32'h0, 1'b1, 1'b1}) begin errs++; $display("FAIL rst_live[%0d]: got %h/%b/%b want 00000000/1/1", a, q4, qv4, e4); end
    end
    restore = 1'b1; re = 1'b1; raddr = 2'd1; tick(); restore = 1'b0; re = 1'b0;
    vec++;
    if ({q4, qv4, e4} !== {32'h0, 1'b1, 1'b1}) begin errs++; $display("FAIL rst_shadow: got %h/%b/%b want 00000000/1/1", q4, qv4, e4); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      we = r[0]; waddr = r[2:1]; wbe = r[6:3]; big = r[7]; raddr = r[9:8];
      re = r[11:10] != 2'b00;
      save = r[15:12] == 4'h0;
      restore = r[19:16] == 4'h0;
      rst_n = r[25:20] != 6'h0;
      d = $urandom;
      tick();
      vec++;
      if ({q4, qv4, e4} !== {mq[0], mv[0], me[0]}) begin errs++; $display("FAIL rand_d4 #%0d: got %h/%b/%b want %h/%b/%b", i, q4, qv4, e4, mq[0], mv[0], me[0]); end
      vec++;
      if ({q3, qv3, e3} !== {mq[1], mv[1], me[1]}) begin errs++; $display("FAIL rand_d3 #%0d: got %h/%b/%b want %h/%b/%b", i, q3, qv3, e3, mq[1], mv[1], me[1]); end
    end
    we = 1'b0; re = 1'b0; save = 1'b0; restore = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_endian();
    test_strobes();
    test_forward();
    test_banking();
    test_reset_during_save();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
